fft_input_loader: RTL
=====================

FFT_INPUT_LOADER -- requirements
Module: fft_input_loader

Interface
REQ-001 SHALL have parameter M, default 9, meaning log2 of frame length (N = 2^M samples).
REQ-002 SHALL have parameter W, default 16, meaning real sample width in bits.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port s_valid  input  1  upstream sample valid.
REQ-006 SHALL have port s_ready  output  1  loader can accept a sample this cycle.
REQ-007 SHALL have port s_data  input  W  signed real sample.
REQ-008 SHALL have port mem_we  output  1  sample RAM write enable.
REQ-009 SHALL have port mem_addr  output  M  sample RAM write address.
REQ-010 SHALL have port mem_wdata  output  2W  {real = s_data, imag = 0}; real in upper W bits.
REQ-011 SHALL have port fft_start  output  1  one-cycle pulse: frame fully written.
REQ-012 SHALL have port fft_done  input  1  one-cycle pulse from FFT core: frame consumed.
REQ-013 SHALL have port busy  output  1  high when not in LOAD state.

Function
REQ-014 SHALL implement FSM states LOAD, FLUSH, START, WAIT.
REQ-015 SHALL assert s_ready combinationally iff state == LOAD.
REQ-016 SHALL count accepted samples with M-bit counter cnt; accept = s_valid && s_ready.
REQ-017 SHALL, on accept, register mem_we=1, mem_addr=bitreverse(cnt), mem_wdata={s_data, W'b0} for exactly the next cycle (write latency 1).
REQ-018 SHALL drive mem_we=0 in every cycle not following an accept; mem_addr/mem_wdata hold last value.
REQ-019 SHALL compute bit reversal internally: mem_addr[b] = cnt[M-1-b] for b = 0..M-1.
REQ-020 SHALL increment cnt by 1 per accept; no increment when s_valid low (gaps allowed anywhere).
REQ-021 SHALL, on accept with cnt == N-1, wrap cnt to 0 and transition LOAD -> FLUSH.
REQ-022 SHALL transition FLUSH -> START unconditionally after one cycle (final write completes in FLUSH).
REQ-023 SHALL assert fft_start=1 for exactly the one cycle state == START, then go START -> WAIT.
REQ-024 SHALL remain in WAIT until fft_done=1, then go WAIT -> LOAD (s_ready high next cycle).
REQ-025 SHALL ignore fft_done in LOAD, FLUSH, START.
REQ-026 SHALL ignore s_valid/s_data outside LOAD (no write, no count).
REQ-027 SHALL drive busy = (state != LOAD).
REQ-028 SHALL produce fft_start exactly 2 cycles after the cycle of the N-th accept.

Reset
REQ-029 SHALL, when reset sampled high, set state=LOAD, cnt=0, mem_we=0, mem_addr=0, mem_wdata=0, fft_start=0.
REQ-030 SHALL give reset priority over every transition and accept in the same cycle.
REQ-031 SHALL discard partial frame on mid-load reset; next accepted sample writes address 0.
REQ-032 SHALL, on reset in FLUSH/START/WAIT, suppress any pending fft_start and return to LOAD.
REQ-033 SHALL drive s_ready=1 in the first cycle after reset deasserts.

Verification
REQ-034 Continuous stream, M=9, s_valid held high, s_data = index -> writes at addr 0,256,128,384,...,511 with wdata real = 0,1,2,3,...,511; fft_start one cycle, 2 cycles after 512th accept.
REQ-035 Throttled stream, s_valid toggled every other cycle -> same address/data sequence, mem_we count = 512, no extra writes in gap cycles.
REQ-036 Samples presented in WAIT plus fft_done pulsed during LOAD -> no writes in WAIT, s_ready=0, fft_done in LOAD has no effect; after fft_done in WAIT, next sample writes addr 0.
REQ-037 Reset asserted after 100 accepts -> mem_we=0 next cycle, no fft_start; new frame first write addr 0, fft_start after 512 fresh accepts.
REQ-038 Parameter M=3, samples 0..7 -> addresses 0,4,2,6,1,5,3,7; back-to-back frames with fft_done one cycle after fft_start -> second frame identical sequence.

Source files
------------

// File: rtl/fft_input_loader.sv
// ---------------------------------------------------------------------------
// fft_input_loader
//
// Collects one frame of N = 2^M real samples from a valid/ready stream and
// writes them into the FFT sample RAM in bit-reversed address order, with a
// zero imaginary part, so an in-place decimation-in-time FFT can run directly
// on the RAM contents. Once the last sample of the frame has been written
// the loader pulses fft_start and waits for fft_done before accepting the
// next frame.
//
// Ports
//   clk        system clock, all logic on the rising edge
//   reset      synchronous, active-high reset
//   s_valid    upstream sample valid
//   s_ready    loader can accept a sample this cycle (high only in LOAD)
//   s_data     signed real sample, W bits
//   mem_we     sample RAM write enable (registered, one cycle after accept)
//   mem_addr   sample RAM write address, bit-reversed sample index
//   mem_wdata  {real, imag}; real = sample in the upper W bits, imag = 0
//   fft_start  one-cycle pulse: the whole frame is in RAM
//   fft_done   one-cycle pulse from the FFT core: frame consumed
//   busy       high whenever the loader is not in LOAD
// ---------------------------------------------------------------------------
module fft_input_loader #(
    parameter int M = 9,
    parameter int W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             s_valid,
    output logic             s_ready,
    input  logic [W-1:0]     s_data,
    output logic             mem_we,
    output logic [M-1:0]     mem_addr,
    output logic [2*W-1:0]   mem_wdata,
    output logic             fft_start,
    input  logic             fft_done,
    output logic             busy
);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        FLUSH = 2'd1,
        START = 2'd2,
        WAIT  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;

    logic [M-1:0]       r_cnt;
    logic               r_we;
    logic [M-1:0]       r_addr;
    logic [2*W-1:0]     r_wdata;

    logic               w_accept;
    logic               w_last_accept;

    // Mirror the index bits: address bit b takes counter bit M-1-b.
    function automatic logic [M-1:0] bit_reverse(input logic [M-1:0] v);
        logic [M-1:0] r;
        r = '0;
        for (int b = 0; b < M; b++) begin
            r[b] = v[M-1-b];
        end
        return r;
    endfunction

    assign w_accept      = s_valid && (r_state == LOAD);
    assign w_last_accept = w_accept && (r_cnt == {M{1'b1}});

    // ---- FSM state register ----
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LOAD;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FLUSH exists so that the write registered on the final accept lands in
    // RAM before fft_start is raised.
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            LOAD: begin
                if (w_last_accept) begin
                    w_state_nxt = FLUSH;
                end
            end
            FLUSH: begin
                w_state_nxt = START;
            end
            START: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (fft_done) begin
                    w_state_nxt = LOAD;
                end
            end
            default: begin
                w_state_nxt = LOAD;
            end
        endcase
    end

    // ---- sample counter and RAM write stage ----
    // The counter is exactly M bits wide, so the increment after sample N-1
    // wraps it to 0 ready for the next frame. Address and data hold their
    // last value when no write is issued.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt   <= '0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_we <= w_accept;
            if (w_accept) begin
                r_cnt   <= r_cnt + 1'b1;
                r_addr  <= bit_reverse(r_cnt);
                r_wdata <= {s_data, {W{1'b0}}};
            end
        end
    end

    assign s_ready   = (r_state == LOAD);
    assign busy      = (r_state != LOAD);
    assign fft_start = (r_state == START);
    assign mem_we    = r_we;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

endmodule
